// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 status codes, icodes and data-memory FSM states
package y86_pkg;
   typedef logic [0:3] stat_t;
   localparam stat_t STAT_AOK = 4'b1000;
   localparam stat_t STAT_HLT = 4'b0100;
   localparam stat_t STAT_ADR = 4'b0010;
   localparam stat_t STAT_INS = 4'b0001;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] ICALL = 4'h8;
   localparam logic [3:0] IRET = 4'h9;
   localparam logic [3:0] IPUSHQ = 4'hA;
   localparam logic [3:0] IPOPQ = 4'hB;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
endpackage

// File: rtl/y86_dmem_responder_if.sv
// y86_dmem_responder_if: valid/ready request and response channels of the data memory
interface y86_dmem_responder_if #(parameter int ADDR_W = 64);
   import y86_pkg::*;
   logic req_valid;
   logic req_ready;
   logic req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [63:0] req_wdata;
   logic rsp_valid;
   logic rsp_ready;
   logic [63:0] rsp_rdata;
   stat_t rsp_stat;
   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input req_ready, rsp_valid, rsp_rdata, rsp_stat
   );
   modport slave (
      input req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_stat
   );
endinterface

// File: rtl/y86_dmem_array.sv
// y86_dmem_array: synchronous single-port DEPTH x 64 word array, read data registered on access
module y86_dmem_array #(parameter int DEPTH = 256) (
   input logic clk,
   input logic en,
   input logic we,
   input logic [$clog2(DEPTH)-1:0] idx,
   input logic [63:0] wdata,
   output logic [63:0] rdata
);
   logic [63:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (en) begin
         if (we) mem[idx] <= wdata;
         rdata <= mem[idx];
      end
endmodule

// File: rtl/y86_dmem_responder.sv
// y86_dmem_responder: fixed-latency, bounds-checked data memory answering Y86 memory-stage requests
module y86_dmem_responder
   import y86_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int LATENCY = 2,
   parameter int ADDR_W = 64
) (
   input logic clk,
   input logic rst_n,
   y86_dmem_responder_if.slave bus
);
   localparam int IW = $clog2(DEPTH);
   dmem_state_t state, state_nx;
   logic [3:0] cnt;
   logic wr_q, ld_q;
   logic [ADDR_W-1:0] addr_q, a_addr;
   logic [63:0] wdata_q, a_wdata, rdata;
   stat_t stat_q;
   logic fire, acc, a_wr, fault;
   // with LATENCY==1 the access happens on the accept edge, straight from the request bus
   always_comb begin
      fire = bus.req_valid && state == IDLE;
      acc = (fire && LATENCY == 1) || (state == WAIT && cnt == '0);
      a_wr = state == IDLE ? bus.req_write : wr_q;
      a_addr = state == IDLE ? bus.req_addr : addr_q;
      a_wdata = state == IDLE ? bus.req_wdata : wdata_q;
      fault = a_addr >= ADDR_W'(DEPTH);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         wr_q <= 1'b0;
         addr_q <= '0;
         wdata_q <= '0;
         ld_q <= 1'b0;
         stat_q <= STAT_AOK;
      end else begin
         state <= state_nx;
         if (fire) begin
            cnt <= 4'(LATENCY - 1);
            wr_q <= bus.req_write;
            addr_q <= bus.req_addr;
            wdata_q <= bus.req_wdata;
         end else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
         if (acc) begin
            ld_q <= !a_wr && !fault;
            stat_q <= fault ? STAT_ADR : STAT_AOK;
         end
      end
   always_comb
      state_nx = state == IDLE ? (fire ? (LATENCY == 1 ? RESP : WAIT) : IDLE) :
                 state == WAIT ? (cnt == '0 ? RESP : WAIT) :
                 (bus.rsp_ready ? IDLE : RESP);
   always_comb begin
      bus.req_ready = state == IDLE;
      bus.rsp_valid = state == RESP;
      bus.rsp_rdata = ld_q ? rdata : '0;
      bus.rsp_stat = stat_q;
   end
   y86_dmem_array #(.DEPTH(DEPTH)) u_array (
      .clk(clk),
      .en(acc),
      .we(acc && a_wr && !fault),
      .idx(a_addr[IW-1:0]),
      .wdata(a_wdata),
      .rdata(rdata)
   );
endmodule

// File: tb/tb_y86_dmem_responder.sv
// tb_y86_dmem_responder: directed scoreboard bench over three responders (LATENCY 2, 1, 15)
module tb_y86_dmem_responder;
   import y86_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;
   int sel = 0, checks = 0, errors = 0, cyc = 0, prev_acc = -1;
   logic req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1;
   logic [63:0] req_addr = '0, req_wdata = '0;
   logic rdy, vld;
   logic [63:0] rdata;
   stat_t stat;
   logic rdy_a [3];
   logic vld_a [3];
   logic [63:0] rd_a [3];
   stat_t st_a [3];
   logic [63:0] mdl [3][256];
   logic [67:0] sb [$];
   y86_dmem_responder_if #(.ADDR_W(64)) bus [3] ();
   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int L = g == 0 ? 2 : g == 1 ? 1 : 15;
      assign bus[g].req_valid = req_valid && sel == g;
      assign bus[g].req_write = req_write;
      assign bus[g].req_addr = req_addr;
      assign bus[g].req_wdata = req_wdata;
      assign bus[g].rsp_ready = rsp_ready;
      assign rdy_a[g] = bus[g].req_ready;
      assign vld_a[g] = bus[g].rsp_valid;
      assign rd_a[g] = bus[g].rsp_rdata;
      assign st_a[g] = bus[g].rsp_stat;
      y86_dmem_responder #(.DEPTH(256), .LATENCY(L), .ADDR_W(64)) dut (
         .clk(clk),
         .rst_n(rst_n),
         .bus(bus[g])
      );
   end
   always_comb begin
      rdy = rdy_a[sel];
      vld = vld_a[sel];
      rdata = rd_a[sel];
      stat = st_a[sel];
   end
   always @(posedge clk) cyc <= cyc + 1;
   // edges from accept to rsp_valid; LATENCY==1 responds on the accept edge itself
   function automatic int exp_edges(int s);
      return s == 0 ? 2 : s == 1 ? 0 : 15;
   endfunction
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got %h exp %h", tag, obs, exp);
      end
   endtask
   task automatic txn(input logic w, input logic [63:0] a, input logic [63:0] d, input logic keep, input string tag);
      logic [67:0] e;
      int n;
      sb.push_back({(w || a >= 256) ? 64'd0 : mdl[sel][a[7:0]], a >= 256 ? STAT_ADR : STAT_AOK});
      if (w && a < 256) mdl[sel][a[7:0]] = d;
      req_write = w;
      req_addr = a;
      req_wdata = d;
      req_valid = 1'b1;
      n = 0;
      while (!rdy && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, " ready"}, 64'(rdy), 64'd1);
      @(posedge clk);
      #1;
      if (keep && prev_acc >= 0) chk({tag, " interval"}, 64'(cyc - prev_acc), 64'd2);
      prev_acc = cyc;
      if (!keep) req_valid = 1'b0;
      n = 0;
      while (!vld && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, " latency"}, 64'(n), 64'(exp_edges(sel)));
      e = sb.pop_front();
      chk({tag, " rdata"}, rdata, e[67:4]);
      chk({tag, " stat"}, 64'(stat), 64'(e[3:0]));
   endtask
   task automatic done(input string tag);
      @(posedge clk);
      #1;
      chk({tag, " idle vld"}, 64'(vld), 64'd0);
      chk({tag, " idle rdy"}, 64'(rdy), 64'd1);
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, " rdy"}, 64'(rdy), 64'd1);
      chk({tag, " vld"}, 64'(vld), 64'd0);
      chk({tag, " rdata"}, rdata, 64'd0);
      chk({tag, " stat"}, 64'(stat), 64'(STAT_AOK));
   endtask
   initial begin
      #1 rst_n = 1'b0;
      #1 chk_reset("rst0");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      txn(1'b1, 64'd5, 64'h1122334455667788, 1'b0, "st5");
      done("st5");
      txn(1'b0, 64'd5, 64'd0, 1'b0, "ld5");
      done("ld5");
      txn(1'b1, 64'd255, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "st255");
      done("st255");
      txn(1'b0, 64'd255, 64'd0, 1'b0, "ld255");
      done("ld255");
      txn(1'b0, 64'd256, 64'd0, 1'b0, "ld256");
      done("ld256");
      txn(1'b1, 64'd44, 64'h4444, 1'b0, "st44");
      done("st44");
      txn(1'b1, 64'd300, 64'hBAD, 1'b0, "st300");
      done("st300");
      txn(1'b0, 64'd44, 64'd0, 1'b0, "ld44");
      done("ld44");
      txn(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, "ldmax");
      done("ldmax");
      rsp_ready = 1'b0;
      txn(1'b0, 64'd5, 64'd0, 1'b0, "bp");
      req_write = 1'b1;
      req_addr = 64'd6;
      req_wdata = 64'h66;
      req_valid = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #1;
         chk("bp vld", 64'(vld), 64'd1);
         chk("bp rdata", rdata, 64'h1122334455667788);
         chk("bp stat", 64'(stat), 64'(STAT_AOK));
         chk("bp rdy", 64'(rdy), 64'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      done("bp");
      chk("bp held rdata", rdata, 64'h1122334455667788);
      @(posedge clk);
      #1;
      chk("bp ignored", 64'(vld), 64'd0);
      txn(1'b1, 64'd9, 64'hA, 1'b0, "st9");
      done("st9");
      txn(1'b0, 64'd9, 64'd0, 1'b0, "ld9");
      done("ld9");
      req_write = 1'b1;
      req_addr = 64'd9;
      req_wdata = 64'hDEAD;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      chk("wait rdy", 64'(rdy), 64'd0);
      chk("wait rdata", rdata, 64'hA);
      #1 rst_n = 1'b0;
      #1 chk_reset("rstmid");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      txn(1'b0, 64'd9, 64'd0, 1'b0, "ld9rst");
      done("ld9rst");
      sel = 1;
      prev_acc = -1;
      txn(1'b1, 64'd7, 64'h77, 1'b1, "b2b0");
      txn(1'b0, 64'd7, 64'd0, 1'b1, "b2b1");
      txn(1'b1, 64'd7, 64'h7777, 1'b1, "b2b2");
      txn(1'b0, 64'd7, 64'd0, 1'b1, "b2b3");
      req_valid = 1'b0;
      done("b2b");
      sel = 2;
      txn(1'b1, 64'd3, 64'h3333_0000_3333, 1'b0, "l15st");
      done("l15st");
      txn(1'b0, 64'd3, 64'd0, 1'b0, "l15ld");
      done("l15ld");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
